// File: rtl/inst_mem_pkg.sv
// Shared types, constants and address helpers for the riscie instruction memory.
// The INST_MEM_FAULT_EN build option is consumed by inst_mem_ctrl.
package inst_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int          MAX_LATENCY = 4;
    localparam int unsigned FAULT_DATA  = 0;

    // Word index of a byte address, wrapped to a store of 2**depth_log2 words.
    function automatic logic [31:0] word_index(input logic [63:0] addr,
                                               input int unsigned depth_log2);
        logic [63:0] mask;
        mask = (64'd1 << depth_log2) - 64'd1;
        return 32'((addr >> 2) & mask);
    endfunction

    // True when the byte address maps to an existing word of the store.
    function automatic logic in_range(input logic [63:0] addr,
                                      input int unsigned depth_log2);
        return (addr >> (depth_log2 + 2)) == 64'd0;
    endfunction

endpackage

// File: rtl/inst_mem_ctrl_if.sv
// Fetch-side request/response bus between the fetch stage (master) and the
// instruction memory (slave).
interface inst_mem_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_fault;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_fault
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_fault
    );
endinterface

// File: rtl/inst_mem_array.sv
// Word-wide instruction store: one synchronous write port and one
// asynchronous read port.
module inst_mem_array #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 16
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_W-1:0]     rdata
);
    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    // NOTE: storage arrays take no reset, so they map onto RAM macros; the
    // program image is always written through the load port before use.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/inst_mem_ctrl.sv
// Instruction memory controller: request/response fetch with LATENCY-cycle
// read latency and a program-load port. Optional fault checks: INST_MEM_FAULT_EN.
module inst_mem_ctrl
    import inst_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 16,
    parameter int LATENCY    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    inst_mem_ctrl_if.slave      bus,
    input  logic                load_en,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [DATA_W-1:0]   load_data,
    output logic                busy
);
    localparam int              CNT_W    = $clog2(MAX_LATENCY);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  fault_q, fault_d;
    logic                  accept;
    logic                  req_fault;
    logic                  load_ok;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic [DEPTH_LOG2-1:0] load_idx;
    logic [DATA_W-1:0]     rd_data;
    logic [DATA_W-1:0]     fetch_data;

    assign req_idx  = DEPTH_LOG2'(word_index(64'(bus.req_addr), DEPTH_LOG2));
    assign load_idx = DEPTH_LOG2'(word_index(64'(load_addr), DEPTH_LOG2));
    assign load_ok  = load_en && in_range(64'(load_addr), DEPTH_LOG2);

`ifdef INST_MEM_FAULT_EN
    assign req_fault = (bus.req_addr[1:0] != 2'b00) || !in_range(64'(bus.req_addr), DEPTH_LOG2);
`else
    assign req_fault = 1'b0;
`endif

    inst_mem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (load_ok),
        .waddr (load_idx),
        .wdata (load_data),
        .raddr (req_idx),
        .rdata (rd_data)
    );

    // Loads own the store for the cycle, so a fetch never races a write.
    assign bus.req_ready = !load_en && (state_q == IDLE || (state_q == RESP && bus.rsp_ready));
    assign accept        = bus.req_valid && bus.req_ready;
    assign fetch_data    = req_fault ? DATA_W'(FAULT_DATA) : rd_data;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        fault_d = fault_q;
        if (accept) begin
            data_d  = fetch_data;
            fault_d = req_fault;
            state_d = (LATENCY == 1) ? RESP : WAIT;
            cnt_d   = CNT_INIT;
        end else begin
            case (state_q)
                WAIT: begin
                    if (cnt_q == '0) state_d = RESP;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                RESP: begin
                    if (bus.rsp_ready) state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            fault_q <= fault_d;
        end
    end

    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = data_q;
    assign bus.rsp_fault = fault_q;
    assign busy          = (state_q != IDLE);
endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Self-checking bench for inst_mem_ctrl: three instances (LATENCY 1/3/4,
// DEPTH_LOG2 8/8/4) share stimulus; one is selected for checking at a time.
`timescale 1ns/1ps
module tb_inst_mem_ctrl;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

`ifdef INST_MEM_FAULT_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        fault;
    } vec_t;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_ready;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              busy_a, busy_b, busy_c;

    int checks = 0;
    int errors = 0;
    int sel    = 0;

    logic              o_req_ready, o_rsp_valid, o_rsp_fault, o_busy;
    logic [DATA_W-1:0] o_rsp_data;
    logic [31:0]       mdl_mem [256];

    inst_mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_a ();
    inst_mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_b ();
    inst_mem_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if_c ();

    assign if_a.req_valid = req_valid;
    assign if_a.req_addr  = req_addr;
    assign if_a.rsp_ready = rsp_ready;
    assign if_b.req_valid = req_valid;
    assign if_b.req_addr  = req_addr;
    assign if_b.rsp_ready = rsp_ready;
    assign if_c.req_valid = req_valid;
    assign if_c.req_addr  = req_addr;
    assign if_c.rsp_ready = rsp_ready;

    inst_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_LOG2(8), .LATENCY(1)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .busy(busy_a));
    inst_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_LOG2(8), .LATENCY(3)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .busy(busy_b));
    inst_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_LOG2(4), .LATENCY(4)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .busy(busy_c));

    always_comb begin
        case (sel)
            1: begin
                o_req_ready = if_b.req_ready; o_rsp_valid = if_b.rsp_valid;
                o_rsp_data  = if_b.rsp_data;  o_rsp_fault = if_b.rsp_fault; o_busy = busy_b;
            end
            2: begin
                o_req_ready = if_c.req_ready; o_rsp_valid = if_c.rsp_valid;
                o_rsp_data  = if_c.rsp_data;  o_rsp_fault = if_c.rsp_fault; o_busy = busy_c;
            end
            default: begin
                o_req_ready = if_a.req_ready; o_rsp_valid = if_a.rsp_valid;
                o_rsp_data  = if_a.rsp_data;  o_rsp_fault = if_a.rsp_fault; o_busy = busy_a;
            end
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int lat_of(input int s);
        return (s == 0) ? 1 : (s == 1) ? 3 : 4;
    endfunction

    function automatic int dep_of(input int s);
        return (s == 2) ? 4 : 8;
    endfunction

    // Reference fetch result from the byte address, store depth and fault option.
    function automatic void expect_fetch(input logic [31:0] addr, input int d,
                                         output logic [31:0] data, output logic fault);
        int unsigned idx;
        int unsigned words;
        idx   = addr >> 2;
        words = 1 << d;
        fault = FE && ((addr % 4) != 0 || idx >= words);
        data  = fault ? 32'h0 : mdl_mem[idx % words];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (sel %0d, t=%0t): got 0x%0h, expected 0x%0h", name, sel, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        req_valid = 1'b0;
        load_en   = 1'b0;
        rsp_ready = 1'b1;
        repeat (6) tick();
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        load_en   = 1'b0;
        rsp_ready = 1'b1;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // One fetch on the selected instance; optionally a load in the cycle after accept.
    task automatic fetch(input logic [31:0] addr, input bit ld, input logic [31:0] la,
                         input logic [31:0] ldd, output logic [31:0] data,
                         output logic fault, output int lat);
        int n;
        lat       = -1;
        data      = 'x;
        fault     = 1'bx;
        req_valid = 1'b1;
        req_addr  = addr;
        rsp_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!o_req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!o_req_ready) begin
            check("fetch accept timeout", 32'(o_req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        tick();
        req_valid = 1'b0;
        if (ld) begin
            load_en   = 1'b1;
            load_addr = la;
            load_data = ldd;
        end
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (o_rsp_valid) begin
                data  = o_rsp_data;
                fault = o_rsp_fault;
                lat   = i;
                break;
            end
            tick();
            load_en = 1'b0;
        end
        load_en = 1'b0;
        if (lat < 0) check("fetch response timeout", 32'(o_rsp_valid), 32'd1);
        tick();
    endtask

    logic [31:0] f_data;
    logic        f_fault;
    int          f_lat;
    vec_t        tbl [7];

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b1;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;

        // Reset values on every instance, during and after reset.
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            check("rst rsp_valid low", 32'(o_rsp_valid), 32'd0);
            check("rst busy low", 32'(o_busy), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            check("post-rst rsp_valid", 32'(o_rsp_valid), 32'd0);
            check("post-rst rsp_data", o_rsp_data, 32'd0);
            check("post-rst rsp_fault", 32'(o_rsp_fault), 32'd0);
            check("post-rst busy", 32'(o_busy), 32'd0);
            check("post-rst req_ready", 32'(o_req_ready), 32'd1);
        end
        tick();

        // Preload; the second load collides with a request and must block it.
        sel = 0;
        do_load(32'h0, 32'hA);
        load_en = 1'b1; load_addr = 32'h2A8; load_data = 32'hAA;
        req_valid = 1'b1; req_addr = 32'h0;
        @(negedge clk);
        check("load blocks req_ready a", 32'(if_a.req_ready), 32'd0);
        check("load blocks req_ready b", 32'(if_b.req_ready), 32'd0);
        check("load blocks req_ready c", 32'(if_c.req_ready), 32'd0);
        tick();
        load_en = 1'b0; req_valid = 1'b0;

        // Back-to-back fetches at LATENCY=1.
        sel = 0;
        req_valid = 1'b1; req_addr = 32'h0;
        @(negedge clk);
        check("b2b ready first", 32'(o_req_ready), 32'd1);
        tick();
        req_addr = 32'h2A8;
        @(negedge clk);
        check("b2b valid first", 32'(o_rsp_valid), 32'd1);
        check("b2b data first", o_rsp_data, 32'hA);
        check("b2b ready second", 32'(o_req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b valid second", 32'(o_rsp_valid), 32'd1);
        check("b2b data second", o_rsp_data, 32'hAA);
        tick();
        @(negedge clk);
        check("b2b idle valid", 32'(o_rsp_valid), 32'd0);
        check("b2b idle busy", 32'(o_busy), 32'd0);
        drain();

        // LATENCY=3 with response back-pressure.
        sel = 1;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 32'h2A8;
        @(negedge clk);
        check("lat3 accept ready", 32'(o_req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            check("lat3 valid early", 32'(o_rsp_valid), 32'd0);
            check("lat3 busy wait", 32'(o_busy), 32'd1);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("lat3 valid held", 32'(o_rsp_valid), 32'd1);
            check("lat3 data held", o_rsp_data, 32'hAA);
            check("lat3 ready stalled", 32'(o_req_ready), 32'd0);
            check("lat3 busy resp", 32'(o_busy), 32'd1);
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("lat3 release ready", 32'(o_req_ready), 32'd1);
        check("lat3 release valid", 32'(o_rsp_valid), 32'd1);
        tick();
        @(negedge clk);
        check("lat3 done valid", 32'(o_rsp_valid), 32'd0);
        check("lat3 done busy", 32'(o_busy), 32'd0);
        drain();

        // Reset pulse while in WAIT at LATENCY=4.
        sel = 2;
        req_valid = 1'b1; req_addr = 32'h0;
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        check("rstwait busy before", 32'(o_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstwait valid async", 32'(o_rsp_valid), 32'd0);
        check("rstwait busy async", 32'(o_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rstwait no response", 32'(o_rsp_valid), 32'd0);
        end
        tick();
        fetch(32'h0, 1'b0, 32'h0, 32'h0, f_data, f_fault, f_lat);
        check("rstwait store kept", f_data, 32'hA);
        check("rstwait latency", 32'(f_lat), 32'd4);
        drain();

        // Load to a word whose fetch is in flight returns the old value.
        sel = 1;
        fetch(32'h0, 1'b1, 32'h0, 32'h55, f_data, f_fault, f_lat);
        check("inflight old data", f_data, 32'hA);
        check("inflight latency", 32'(f_lat), 32'd3);
        fetch(32'h0, 1'b0, 32'h0, 32'h0, f_data, f_fault, f_lat);
        check("inflight new data", f_data, 32'h55);
        drain();

        // Address mapping / fault table on the 16-word instance.
        sel = 2;
        do_load(32'h4, 32'h1111_1111);
        do_load(32'h3C, 32'hF0F0_F0F0);
        tbl[0] = '{32'h00, 32'h55, 1'b0};
        tbl[1] = '{32'h04, 32'h1111_1111, 1'b0};
        tbl[2] = '{32'h3C, 32'hF0F0_F0F0, 1'b0};
        if (FE) begin
            tbl[3] = '{32'h02, 32'h0, 1'b1};
            tbl[4] = '{32'h07, 32'h0, 1'b1};
            tbl[5] = '{32'h40, 32'h0, 1'b1};
            tbl[6] = '{32'h7C, 32'h0, 1'b1};
        end else begin
            tbl[3] = '{32'h02, 32'h55, 1'b0};
            tbl[4] = '{32'h07, 32'h1111_1111, 1'b0};
            tbl[5] = '{32'h40, 32'h55, 1'b0};
            tbl[6] = '{32'h7C, 32'hF0F0_F0F0, 1'b0};
        end
        for (int i = 0; i < 7; i++) begin
            fetch(tbl[i].addr, 1'b0, 32'h0, 32'h0, f_data, f_fault, f_lat);
            check($sformatf("tbl[%0d] data", i), f_data, tbl[i].data);
            check($sformatf("tbl[%0d] fault", i), 32'(f_fault), 32'(tbl[i].fault));
            check($sformatf("tbl[%0d] latency", i), 32'(f_lat), 32'd4);
        end

        // Randomized traffic against a transaction-age reference model.
        for (int s = 0; s < 3; s++) begin
            bit          have;
            int          age;
            int          lat;
            logic [31:0] exp_d;
            logic        exp_f;
            logic        exp_valid, exp_ready;
            do_reset();
            sel = s;
            lat = lat_of(s);
            for (int w = 0; w < 256; w++) begin
                mdl_mem[w] = $urandom;
                do_load(32'(w * 4 + $urandom_range(0, 3)), mdl_mem[w]);
            end
            have  = 1'b0;
            age   = 0;
            exp_d = '0;
            exp_f = 1'b0;
            for (int c = 0; c < 400; c++) begin
                req_valid = ($urandom_range(0, 3) != 0);
                req_addr  = ($urandom_range(0, 9) < 7) ? (32'($urandom_range(0, 255)) << 2)
                                                       : 32'($urandom_range(0, 2047));
                rsp_ready = ($urandom_range(0, 3) != 0);
                load_en   = ($urandom_range(0, 9) == 0);
                load_addr = 32'($urandom_range(0, 2047));
                load_data = $urandom;
                @(negedge clk);
                exp_valid = have && (age >= lat);
                exp_ready = !load_en && (!have || (exp_valid && rsp_ready));
                check("rand req_ready", 32'(o_req_ready), 32'(exp_ready));
                check("rand rsp_valid", 32'(o_rsp_valid), 32'(exp_valid));
                check("rand busy", 32'(o_busy), 32'(have));
                if (exp_valid) begin
                    check("rand rsp_data", o_rsp_data, exp_d);
                    check("rand rsp_fault", 32'(o_rsp_fault), 32'(exp_f));
                end
                @(posedge clk);
                if (exp_valid && rsp_ready) have = 1'b0;
                if (have) age++;
                if (req_valid && exp_ready) begin
                    have = 1'b1;
                    age  = 1;
                    expect_fetch(req_addr, dep_of(s), exp_d, exp_f);
                end
                if (load_en && (load_addr >> 2) < 256) mdl_mem[load_addr >> 2] = load_data;
                #1;
            end
        end

        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
